// File: rtl/sample_debounce_pkg.sv
// Shared types and default parameters for the sample_debounce slice.
// Also provides the parameter legality check used at elaboration.
package sample_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_STABLE = 1'b0;
    localparam state_t ST_CHECK  = 1'b1;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STABLE_CYCLES = 3;
    localparam int DEF_CNT_W         = 4;
    localparam int DEF_EVT_W         = 8;

    // The stability counter must be able to hold STABLE_CYCLES-1 and reach the threshold.
    function automatic bit stable_cycles_ok(input int stable_cycles, input int cnt_w);
        return (stable_cycles >= 1) && (stable_cycles < (1 << cnt_w));
    endfunction

    localparam bit DEF_PARAMS_OK = stable_cycles_ok(DEF_STABLE_CYCLES, DEF_CNT_W);

endpackage

// File: rtl/sample_debounce_sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear coincident with an increment leaves the count at one, so that event is not lost.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Q_MAX = {W{1'b1}};

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear wins, increment saturates at all-ones.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            if (inc) begin
                q_d = W'(1'b1);
            end else begin
                q_d = {W{1'b0}};
            end
        end else if (inc && (q_q != Q_MAX)) begin
            q_d = q_q + W'(1'b1);
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sample_debounce.sv
// Debounce filter for the registered sample bus: a new value is accepted only after it
// holds for STABLE_CYCLES consecutive enabled clocks; publishes edge pulses and a commit count.
module sample_debounce
    import sample_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int EVT_W         = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             evt_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg,
    output logic             busy,
    output logic [EVT_W-1:0] evt_cnt
);

    if (!stable_cycles_ok(STABLE_CYCLES, CNT_W)) begin : g_param_check
        $error("sample_debounce: STABLE_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic             chg_q,   chg_d;
    logic             busy_q,  busy_d;
    logic             commit_s;
    logic [WIDTH-1:0] new_val_s;

    // Qualification FSM: decides when the candidate has held long enough to commit.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        commit_s  = 1'b0;
        new_val_s = dout_q;
        if (en) begin
            case (state_q)
                ST_STABLE: begin
                    if (din != dout_q) begin
                        if (STABLE_CYCLES == 1) begin
                            commit_s  = 1'b1;
                            new_val_s = din;
                        end else begin
                            cand_d  = din;
                            cnt_d   = CNT_ONE;
                            state_d = ST_CHECK;
                        end
                    end else begin
                        state_d = ST_STABLE;
                    end
                end
                ST_CHECK: begin
                    if (din == dout_q) begin
                        // Input fell back to the accepted value: drop the candidate.
                        state_d = ST_STABLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (din != cand_q) begin
                        cand_d = din;
                        cnt_d  = CNT_ONE;
                    end else if ((cnt_q + CNT_ONE) == CNT_TARGET) begin
                        commit_s  = 1'b1;
                        new_val_s = cand_q;
                        state_d   = ST_STABLE;
                        cnt_d     = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output next-state: accepted value, edge pulses and status.
    always_comb begin
        if (commit_s) begin
            dout_d = new_val_s;
            rise_d = new_val_s & ~dout_q;
            fall_d = ~new_val_s & dout_q;
            chg_d  = 1'b1;
        end else begin
            dout_d = dout_q;
            rise_d = {WIDTH{1'b0}};
            fall_d = {WIDTH{1'b0}};
            chg_d  = 1'b0;
        end
        busy_d = (state_d == ST_CHECK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cand_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            dout_q  <= {WIDTH{1'b0}};
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
            busy_q  <= busy_d;
        end
    end

    sat_counter #(
        .W (EVT_W)
    ) u_evt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (evt_clr),
        .inc (commit_s),
        .q   (evt_cnt)
    );

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign chg  = chg_q;
    assign busy = busy_q;

endmodule

// File: doc/sample_debounce.md
Name: sample_debounce

Overview:
Downstream consumer of the 4-bit sampled-input flop stage. It filters the registered sample bus so that a new value is accepted only after it holds for STABLE_CYCLES consecutive enabled clocks. It publishes the accepted value, per-bit rise and fall pulses, a change strobe, and a saturating count of accepted changes for the control and status logic.

Parameters:
WIDTH, 4, width of the sampled data bus.
STABLE_CYCLES, 3, consecutive identical enabled samples required to accept a value; legal range is 1 to 2^CNT_W-1.
CNT_W, 4, width of the internal stability counter.
EVT_W, 8, width of the accepted-change event counter.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  sample enable; when low, din is ignored and all state holds.
din  in  WIDTH  registered sample from the upstream sampling flop.
evt_clr  in  1  synchronous clear of evt_cnt.
dout  out  WIDTH  debounced, accepted value.
rise  out  WIDTH  one-cycle pulse per bit that went 0->1 at commit.
fall  out  WIDTH  one-cycle pulse per bit that went 1->0 at commit.
chg  out  1  one-cycle pulse on every commit.
busy  out  1  high while a candidate value is being qualified (state CHECK).
evt_cnt  out  EVT_W  saturating count of commits.

Behaviour:
- Reset (rst=1 at an edge): dout=0, rise=0, fall=0, chg=0, busy=0, evt_cnt=0, cand=0, cnt=0, state=STABLE. Reset has priority over every other input.
- Reset asserted mid-CHECK discards the candidate. No commit or pulse is produced.
- Internal registers: cand (WIDTH bits), cnt (CNT_W bits), state in {STABLE, CHECK}.
- en=0: state, cand, cnt, dout and evt_cnt hold; rise, fall and chg are 0. evt_clr is still honoured.
- STABLE, en=1, din==dout: no change.
- STABLE, en=1, din!=dout:
  - If STABLE_CYCLES==1, commit immediately.
  - Otherwise cand<=din, cnt<=1, state<=CHECK.
- CHECK, en=1, din==dout: glitch. state<=STABLE, cnt<=0, no commit.
- CHECK, en=1, din!=dout, din!=cand: restart. cand<=din, cnt<=1.
- CHECK, en=1, din==cand:
  - If cnt+1==STABLE_CYCLES, commit and state<=STABLE.
  - Otherwise cnt<=cnt+1.
- Commit, registered at the same edge:
  - dout<=new value; rise<=new & ~dout_old; fall<=~new & dout_old; chg<=1.
  - All three pulses are high for exactly one cycle, then return to 0.
- Latency: a value first sampled at edge E0 and held commits at edge E(STABLE_CYCLES-1). dout is visible after STABLE_CYCLES edges counted from E0 inclusive.
- busy = (state==CHECK), registered.
- evt_cnt:
  - Increments by 1 per commit and saturates at 2^EVT_W-1 (no wrap).
  - evt_clr alone: evt_cnt<=0.
  - evt_clr coincident with a commit: evt_cnt<=1.
- Back-to-back commits are allowed. A new difference seen at the cycle after a commit starts CHECK immediately.

Decomposition:
- Shared package sample_pkg holds:
  - the state typedef (ST_STABLE, ST_CHECK);
  - default WIDTH/STABLE_CYCLES/CNT_W/EVT_W constants;
  - a compile-time check that STABLE_CYCLES < 2**CNT_W.
- One sub-module: sat_counter (params W; inputs clk, rst, clr, inc; output q). It implements evt_cnt, including the clr+inc gives 1 rule.

Test Plan:
1. WIDTH=4, STABLE_CYCLES=3, en=1. Reset, release, then din=0101 held -> dout=0101 three edges later; rise=0101, fall=0000, chg one cycle; evt_cnt=1.
2. Then din=1010 held 3 cycles -> dout=1010, rise=1010, fall=0101, chg one cycle; evt_cnt=2.
3. Glitch: din=1111 for 2 cycles, then 1010 -> busy high 2 cycles then low; dout stays 1010; no chg; evt_cnt=2.
4. Restart: din=0000 for 2 cycles, then 0011 held -> commit 0011 on the 3rd 0011 sample, never 0000; rise=0001, fall=1000.
5. en gating: din=1100 held, en pattern 1,0,0,1,1 -> commit only on the 5th edge; pulses are 0 while en=0.
6. EVT_W=2: five commits -> evt_cnt saturates at 3; evt_clr with a commit -> evt_cnt=1; rst during CHECK -> all outputs 0 at the next edge, no pulse.
